// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, display-slave register offsets and the
// result-master FSM state type.
// Optional feature macro ASL_READBACK_EN adds the read-back states RB_A/RB_D.
package ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NSEQ   = 2'b10;
    localparam logic [1:0]  HTRANS_SEQ    = 2'b11;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [3:0]  HPROT_DATA    = 4'b0011;

    // Seven-segment display slave registers, relative to its base address
    localparam logic [31:0] SSD_DATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] SSD_DONE_OFS  = 32'h0000_0004;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A0   = 3'd1,
        ST_D0A1 = 3'd2,
        ST_D1   = 3'd3
`ifdef ASL_READBACK_EN
        ,
        ST_RB_A = 3'd4,
        ST_RB_D = 3'd5
`endif
    } mst_state_e;

endpackage

// File: rtl/ahb_result_master_if.sv
// ahb_result_master_if: classifier result handshake plus AHB-Lite master bus.
//   res_valid_i/res_class_i/res_ready_o : result handshake (5-bit class index)
//   ahb_m_*_o                           : AHB-Lite address/control/write data
//   ahb_m_hrdata_i/hready_i/hresp_i     : AHB-Lite slave response
// Modport master is the result master's view, slave the opposite side.
interface ahb_result_master_if;

    logic        res_valid_i;
    logic [4:0]  res_class_i;
    logic        res_ready_o;

    logic [31:0] ahb_m_haddr_o;
    logic        ahb_m_hwrite_o;
    logic [2:0]  ahb_m_hsize_o;
    logic [2:0]  ahb_m_hburst_o;
    logic [3:0]  ahb_m_hprot_o;
    logic [1:0]  ahb_m_htrans_o;
    logic        ahb_m_hmastlock_o;
    logic [31:0] ahb_m_hwdata_o;

    logic [31:0] ahb_m_hrdata_i;
    logic        ahb_m_hready_i;
    logic        ahb_m_hresp_i;

    modport master (
        input  res_valid_i, res_class_i,
        output res_ready_o,
        output ahb_m_haddr_o, ahb_m_hwrite_o, ahb_m_hsize_o, ahb_m_hburst_o,
        output ahb_m_hprot_o, ahb_m_htrans_o, ahb_m_hmastlock_o, ahb_m_hwdata_o,
        input  ahb_m_hrdata_i, ahb_m_hready_i, ahb_m_hresp_i
    );

    modport slave (
        output res_valid_i, res_class_i,
        input  res_ready_o,
        input  ahb_m_haddr_o, ahb_m_hwrite_o, ahb_m_hsize_o, ahb_m_hburst_o,
        input  ahb_m_hprot_o, ahb_m_htrans_o, ahb_m_hmastlock_o, ahb_m_hwdata_o,
        output ahb_m_hrdata_i, ahb_m_hready_i, ahb_m_hresp_i
    );

endinterface

// File: rtl/ahb_result_master.sv
// ahb_result_master: takes one classifier result at a time and reports it to
// the display slave as two AHB-Lite single writes: class to BASE_ADDR, then
// 0x1 to BASE_ADDR+4 (done). The second address phase overlaps the first
// data phase.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : result handshake + AHB-Lite master
//   busy_o        : a sequence is in flight
//   err_o         : sticky, set by an error response (or read-back mismatch)
//   done_cnt_o    : completed sequences, wraps at 2^CNT_W
// Macro ASL_READBACK_EN: after the done write, read BASE_ADDR back and flag
// err_o if the low five bits differ from the class written.
//
// state | meaning
// IDLE  | ready for a result, bus idle
// A0    | address phase of the class write
// D0A1  | class write data phase + address phase of the done write
// D1    | done write data phase
// RB_A  | read-back address phase (ASL_READBACK_EN only)
// RB_D  | read-back data phase, compare (ASL_READBACK_EN only)
module ahb_result_master
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    ahb_result_master_if.master bus,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    mst_state_e       state_q, state_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic [1:0]       htrans_q, htrans_d;
    logic             hwrite_q, hwrite_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [4:0]       class_q, class_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.res_valid_i && ready_q) begin
                    class_d = bus.res_class_i;
                    state_d = ST_A0;
                end
            end
            ST_A0: begin
                if (bus.ahb_m_hready_i) state_d = ST_D0A1;
            end
            ST_D0A1: begin
                if (bus.ahb_m_hresp_i)  err_d   = 1'b1;
                if (bus.ahb_m_hready_i) state_d = ST_D1;
            end
            ST_D1: begin
                if (bus.ahb_m_hresp_i) err_d = 1'b1;
                if (bus.ahb_m_hready_i) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef ASL_READBACK_EN
                    state_d = ST_RB_A;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef ASL_READBACK_EN
            ST_RB_A: begin
                if (bus.ahb_m_hready_i) state_d = ST_RB_D;
            end
            ST_RB_D: begin
                if (bus.ahb_m_hresp_i) err_d = 1'b1;
                if (bus.ahb_m_hready_i) begin
                    if (bus.ahb_m_hrdata_i[4:0] != class_q) err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the next state.
        // Any state that waits on hready re-decodes to the same values, which
        // keeps the bus stable through wait states.
        ready_d  = 1'b0;
        htrans_d = HTRANS_IDLE;
        haddr_d  = '0;
        hwrite_d = 1'b0;
        hwdata_d = '0;
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_A0: begin
                htrans_d = HTRANS_NSEQ;
                haddr_d  = BASE_ADDR + SSD_DATA_OFS;
                hwrite_d = 1'b1;
            end
            ST_D0A1: begin
                htrans_d = HTRANS_NSEQ;
                haddr_d  = BASE_ADDR + SSD_DONE_OFS;
                hwrite_d = 1'b1;
                hwdata_d = {27'd0, class_d};
            end
            ST_D1: begin
                haddr_d  = BASE_ADDR + SSD_DONE_OFS;
                hwrite_d = 1'b1;
                hwdata_d = 32'h0000_0001;
            end
`ifdef ASL_READBACK_EN
            ST_RB_A: begin
                htrans_d = HTRANS_NSEQ;
                haddr_d  = BASE_ADDR + SSD_DATA_OFS;
            end
            ST_RB_D: begin
                haddr_d  = BASE_ADDR + SSD_DATA_OFS;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            hwdata_q <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            class_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            class_q  <= class_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.res_ready_o       = ready_q;
    assign bus.ahb_m_haddr_o     = haddr_q;
    assign bus.ahb_m_hwrite_o    = hwrite_q;
    assign bus.ahb_m_htrans_o    = htrans_q;
    assign bus.ahb_m_hwdata_o    = hwdata_q;
    assign bus.ahb_m_hsize_o     = HSIZE_WORD;
    assign bus.ahb_m_hburst_o    = HBURST_SINGLE;
    assign bus.ahb_m_hprot_o     = HPROT_DATA;
    assign bus.ahb_m_hmastlock_o = 1'b0;

    assign busy_o     = (state_q != ST_IDLE);
    assign err_o      = err_q;
    assign done_cnt_o = cnt_q;

endmodule

// File: tb/tb_ahb_result_master.sv
`timescale 1ns/1ps
// Testbench for ahb_result_master: directed sequences plus randomized results
// and random slave wait states. A bus monitor matches every completed AHB
// transfer against a queue of expected transfers pushed when a result is
// accepted.
module tb_ahb_result_master;
    import ahb_pkg::*;

    localparam logic [31:0] BASE = 32'hC000_0000;
`ifdef ASL_READBACK_EN
    localparam int RB_EXTRA = 2;
`else
    localparam int RB_EXTRA = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy, err;
    logic [15:0] done_cnt;

    ahb_result_master_if bus();

    ahb_result_master #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy_o     (busy),
        .err_o      (err),
        .done_cnt_o (done_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    txn_t        exp_q[$];
    txn_t        cur;
    bit          pend = 0, pend_start = 0;
    logic [31:0] pend_addr;
    logic        pend_write;
    int          exp_done = 0;
    bit          exp_err = 0;
    logic [4:0]  mem_class = 5'd0;
    bit          prev_live = 0, prev_pend = 0;
    logic        prev_hready;
    logic [1:0]  prev_htrans;
    logic [31:0] prev_haddr, prev_hwdata;
    logic        prev_hwrite;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend     = 0;
            exp_done = 0;
            exp_err  = 0;
            prev_live = 0;
        end else begin
            if (prev_live && !prev_hready && (prev_htrans == HTRANS_NSEQ || prev_pend)) begin
                chk("hold_haddr",  bus.ahb_m_haddr_o,  prev_haddr);
                chk("hold_htrans", {30'd0, bus.ahb_m_htrans_o}, {30'd0, prev_htrans});
                chk("hold_hwrite", {31'd0, bus.ahb_m_hwrite_o}, {31'd0, prev_hwrite});
                chk("hold_hwdata", bus.ahb_m_hwdata_o, prev_hwdata);
            end
            if (busy) chk("ready_low_while_busy", {31'd0, bus.res_ready_o}, 32'd0);

            pend_start = pend;
            if (pend) begin
                if (bus.ahb_m_hresp_i) exp_err = 1;
                if (bus.ahb_m_hready_i) begin
                    pend = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer actual addr=%h required=none", pend_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("xfer_addr",  pend_addr, cur.addr);
                        chk("xfer_write", {31'd0, pend_write}, {31'd0, cur.write});
                        if (cur.write) begin
                            chk("xfer_wdata", bus.ahb_m_hwdata_o, cur.data);
                            if (cur.addr == BASE) mem_class = bus.ahb_m_hwdata_o[4:0];
                            if (cur.addr == BASE + 32'd4) exp_done++;
                        end else if (bus.ahb_m_hrdata_i[4:0] != cur.data[4:0]) begin
                            exp_err = 1;
                        end
                    end
                end
            end
            if (bus.ahb_m_htrans_o == HTRANS_NSEQ && bus.ahb_m_hready_i) begin
                pend       = 1;
                pend_addr  = bus.ahb_m_haddr_o;
                pend_write = bus.ahb_m_hwrite_o;
            end
            if (bus.res_valid_i && bus.res_ready_o) begin
                exp_q.push_back('{BASE, 1'b1, {27'd0, bus.res_class_i}});
                exp_q.push_back('{BASE + 32'd4, 1'b1, 32'd1});
`ifdef ASL_READBACK_EN
                exp_q.push_back('{BASE, 1'b0, {27'd0, bus.res_class_i}});
`endif
            end
            prev_live = 1;
        end
        prev_pend   = pend_start;
        prev_hready = bus.ahb_m_hready_i;
        prev_htrans = bus.ahb_m_htrans_o;
        prev_haddr  = bus.ahb_m_haddr_o;
        prev_hwrite = bus.ahb_m_hwrite_o;
        prev_hwdata = bus.ahb_m_hwdata_o;
    end

    // ---------------- stimulus ----------------
    bit          wait_mode = 0;
    bit          rd_ovr_en = 0;
    logic [31:0] rd_ovr = '0;
    int          sent = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        bus.ahb_m_hready_i = wait_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.ahb_m_hrdata_i = rd_ovr_en ? rd_ovr : {27'd0, mem_class};
    endtask

    task automatic send(input logic [4:0] c, input bit keep);
        int  n = 0;
        bit  acc = 0;
        bus.res_valid_i = 1'b1;
        bus.res_class_i = c;
        while (!acc && n < 200) begin
            acc = bus.res_ready_o;
            tick();
            n++;
        end
        if (!keep) bus.res_valid_i = 1'b0;
        if (acc) sent++;
        chk("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !bus.res_ready_o) && n < 500) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'd0, (!busy && bus.res_ready_o)}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_htrans"}, {30'd0, bus.ahb_m_htrans_o}, 32'd0);
        chk({tag, "_haddr"},  bus.ahb_m_haddr_o, 32'd0);
        chk({tag, "_hwrite"}, {31'd0, bus.ahb_m_hwrite_o}, 32'd0);
        chk({tag, "_hwdata"}, bus.ahb_m_hwdata_o, 32'd0);
        chk({tag, "_ready"},  {31'd0, bus.res_ready_o}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
        chk({tag, "_err"},    {31'd0, err}, 32'd0);
        chk({tag, "_done"},   {16'd0, done_cnt}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.res_valid_i    = 1'b0;
        bus.res_class_i    = 5'd0;
        bus.ahb_m_hready_i = 1'b1;
        bus.ahb_m_hresp_i  = 1'b0;
        bus.ahb_m_hrdata_i = 32'd0;
        #1 rst = 1'b1;
        #1;
        chk_reset_state("rst");
        chk("const_hsize",  {29'd0, bus.ahb_m_hsize_o},  32'd2);
        chk("const_hburst", {29'd0, bus.ahb_m_hburst_o}, 32'd0);
        chk("const_hprot",  {28'd0, bus.ahb_m_hprot_o},  32'd3);
        chk("const_hmastlock", {31'd0, bus.ahb_m_hmastlock_o}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("ready_before_first_edge", {31'd0, bus.res_ready_o}, 32'd0);
        tick();
        chk("ready_after_rst", {31'd0, bus.res_ready_o}, 32'd1);

        // zero wait states, class 5, cycle-accurate latency
        bus.res_valid_i = 1'b1;
        bus.res_class_i = 5'd5;
        tick();
        bus.res_valid_i = 1'b0;
        sent++;
        chk("a0_htrans", {30'd0, bus.ahb_m_htrans_o}, {30'd0, HTRANS_NSEQ});
        chk("a0_haddr",  bus.ahb_m_haddr_o, BASE);
        chk("a0_hwrite", {31'd0, bus.ahb_m_hwrite_o}, 32'd1);
        chk("a0_ready",  {31'd0, bus.res_ready_o}, 32'd0);
        chk("a0_busy",   {31'd0, busy}, 32'd1);
        tick();
        chk("d0a1_htrans", {30'd0, bus.ahb_m_htrans_o}, {30'd0, HTRANS_NSEQ});
        chk("d0a1_haddr",  bus.ahb_m_haddr_o, BASE + 32'd4);
        chk("d0a1_hwdata", bus.ahb_m_hwdata_o, 32'd5);
        tick();
        chk("d1_htrans", {30'd0, bus.ahb_m_htrans_o}, {30'd0, HTRANS_IDLE});
        chk("d1_hwdata", bus.ahb_m_hwdata_o, 32'd1);
        chk("d1_ready",  {31'd0, bus.res_ready_o}, 32'd0);
        repeat (RB_EXTRA) tick();
        tick();
        chk("n4_ready", {31'd0, bus.res_ready_o}, 32'd1);
        chk("n4_busy",  {31'd0, busy}, 32'd0);
        chk("n4_done",  {16'd0, done_cnt}, 32'd1);

        // three wait states in D0A1
        bus.res_valid_i = 1'b1;
        bus.res_class_i = 5'd5;
        tick();
        bus.res_valid_i = 1'b0;
        sent++;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.ahb_m_hready_i = 1'b0;
            chk("stall_haddr",  bus.ahb_m_haddr_o, BASE + 32'd4);
            chk("stall_hwdata", bus.ahb_m_hwdata_o, 32'd5);
            chk("stall_htrans", {30'd0, bus.ahb_m_htrans_o}, {30'd0, HTRANS_NSEQ});
            tick();
        end
        chk("post_stall_haddr", bus.ahb_m_haddr_o, BASE + 32'd4);
        wait_idle();
        chk("stall_done", {16'd0, done_cnt}, 32'd2);

        // back-to-back 7 then 23 with valid held
        send(5'd7, 1'b1);
        chk("b2b_ready_low", {31'd0, bus.res_ready_o}, 32'd0);
        send(5'd23, 1'b0);
        wait_idle();
        chk("b2b_done", {16'd0, done_cnt}, 32'd4);

        // error response in D1
        chk("err_before", {31'd0, err}, 32'd0);
        bus.res_valid_i = 1'b1;
        bus.res_class_i = 5'd9;
        tick();
        bus.res_valid_i = 1'b0;
        sent++;
        tick();
        tick();
        bus.ahb_m_hresp_i = 1'b1;
        tick();
        bus.ahb_m_hresp_i = 1'b0;
        wait_idle();
        chk("err_set",  {31'd0, err}, 32'd1);
        chk("err_done", {16'd0, done_cnt}, 32'd5);
        send(5'd1, 1'b0);
        wait_idle();
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("err_model",  {31'd0, err}, {31'd0, exp_err});
        chk("after_err_done", {16'd0, done_cnt}, 32'd6);

        // reset during A0
        bus.res_valid_i = 1'b1;
        bus.res_class_i = 5'd12;
        tick();
        bus.res_valid_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        tick();
        tick();
        rst = 1'b0;
        sent = 0;
        chk("midrst_ready_held", {31'd0, bus.res_ready_o}, 32'd0);
        tick();
        chk("midrst_ready_edge", {31'd0, bus.res_ready_o}, 32'd1);
        send(5'd2, 1'b0);
        wait_idle();
        chk("midrst_done", {16'd0, done_cnt}, 32'd1);
        chk("midrst_err",  {31'd0, err}, 32'd0);

        // randomized results and wait states
        wait_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            send(5'($urandom_range(0, 31)), 1'b0);
            repeat (gap) tick();
        end
        wait_idle();
        wait_mode = 0;
        tick();
        chk("rand_done",  {16'd0, done_cnt}, sent);
        chk("rand_model", {16'd0, done_cnt}, exp_done);
        chk("rand_err",   {31'd0, err}, {31'd0, exp_err});
        chk("sb_drained", exp_q.size(), 32'd0);

`ifdef ASL_READBACK_EN
        rd_ovr_en = 1;
        rd_ovr    = 32'h3;
        send(5'd4, 1'b0);
        wait_idle();
        rd_ovr_en = 0;
        chk("rb_err", {31'd0, err}, 32'd1);
        chk("rb_err_model", {31'd0, exp_err}, 32'd1);
        chk("rb_drained", exp_q.size(), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
